// File: rtl/hex_display_ctrl_pkg.sv
// Shared constants, FSM encoding and segment table for the six-digit hex display controller.
package hex_display_ctrl_pkg;

    localparam int         NUM_DIGITS = 6;
    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam logic [6:0] SEG_ZERO   = 7'h40;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_COMMIT,
        ST_HOLD
    } state_t;

    // Active-high segment pattern, bit0 = a .. bit6 = g.
    function automatic logic [6:0] seg_active_high(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h3F;
            4'h1:    pat = 7'h06;
            4'h2:    pat = 7'h5B;
            4'h3:    pat = 7'h4F;
            4'h4:    pat = 7'h66;
            4'h5:    pat = 7'h6D;
            4'h6:    pat = 7'h7D;
            4'h7:    pat = 7'h07;
            4'h8:    pat = 7'h7F;
            4'h9:    pat = 7'h6F;
            4'hA:    pat = 7'h77;
            4'hB:    pat = 7'h7C;
            4'hC:    pat = 7'h39;
            4'hD:    pat = 7'h5E;
            4'hE:    pat = 7'h79;
            default: pat = 7'h71;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/hex_display_ctrl_seg7_lut.sv
// Combinational nibble to active-low seven-segment decoder, shared by all digits.
module seg7_lut
    import hex_display_ctrl_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    assign o_seg = ~seg_active_high(i_nib);

endmodule

// File: rtl/hex_display_ctrl.sv
// Six-digit hex display controller: captures a 24-bit word, decodes one digit per cycle into
// shadow registers, commits all digits on one edge, then holds the display for HOLD_CYCLES.
module hex_display_ctrl
    import hex_display_ctrl_pkg::*;
#(
    parameter int HOLD_CYCLES = 5000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_data,
    input  logic        blank_lz,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic        busy
);

    localparam int             CNT_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = (HOLD_CYCLES == 0) ? '0 : CNT_W'(HOLD_CYCLES - 1);

    state_t           r_state;
    logic [23:0]      r_data;
    logic [2:0]       r_idx;
    logic             r_lz_run;
    logic [CNT_W-1:0] r_cnt;
    logic             r_in_ready;
    logic [6:0]       r_shadow [NUM_DIGITS];
    logic [6:0]       r_hex    [NUM_DIGITS];

    logic             w_hs;
    logic [3:0]       w_nib;
    logic [6:0]       w_seg;
    logic             w_blank;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign w_hs      = in_valid & r_in_ready;
    assign w_nib     = r_data[{r_idx, 2'b00} +: 4];
    assign w_blank   = r_lz_run && (w_nib == 4'h0) && (r_idx != 3'd0);
    assign w_cnt_nxt = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;

    seg7_lut u_lut (
        .i_nib (w_nib),
        .o_seg (w_seg)
    );

    // in_ready is raised one cycle early so a new word is accepted on the very edge the
    // controller would otherwise fall back to IDLE, giving a period of 7 + HOLD_CYCLES.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_data     <= '0;
            r_idx      <= 3'd5;
            r_lz_run   <= 1'b0;
            r_cnt      <= '0;
            r_in_ready <= 1'b1;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_shadow[i] <= SEG_ZERO;
                r_hex[i]    <= SEG_ZERO;
            end
        end else begin
            if (r_state == ST_COMMIT) begin
                for (int i = 0; i < NUM_DIGITS; i++) r_hex[i] <= r_shadow[i];
            end
            if (w_hs) begin
                r_data     <= in_data;
                r_lz_run   <= blank_lz;
                r_idx      <= 3'd5;
                r_in_ready <= 1'b0;
                r_state    <= ST_DECODE;
            end else begin
                case (r_state)
                    ST_IDLE: r_in_ready <= 1'b1;
                    ST_DECODE: begin
                        r_shadow[r_idx] <= w_blank ? SEG_BLANK : w_seg;
                        r_lz_run        <= w_blank;
                        if (r_idx == 3'd0) begin
                            r_state    <= ST_COMMIT;
                            r_in_ready <= (HOLD_CYCLES == 0);
                        end else begin
                            r_idx <= r_idx - 1'b1;
                        end
                    end
                    ST_COMMIT: begin
                        if (HOLD_CYCLES == 0) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state    <= ST_HOLD;
                            r_cnt      <= '0;
                            r_in_ready <= (HOLD_CYCLES == 1);
                        end
                    end
                    ST_HOLD: begin
                        if (r_cnt == HOLD_LAST) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_cnt      <= w_cnt_nxt;
                            r_in_ready <= (w_cnt_nxt == HOLD_LAST);
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign in_ready = r_in_ready;
    assign busy     = (r_state != ST_IDLE);
    assign hex0     = r_hex[0];
    assign hex1     = r_hex[1];
    assign hex2     = r_hex[2];
    assign hex3     = r_hex[3];
    assign hex4     = r_hex[4];
    assign hex5     = r_hex[5];

endmodule

// File: doc/hex_display_ctrl.md
HEX_DISPLAY_CTRL -- requirements
Module: hex_display_ctrl

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 5000000: minimum cycles a committed value stays displayed before the next capture (100 ms at 50 MHz); 0 is legal.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: in_data is offered.
REQ-005 SHALL have port in_ready, output, 1 bit, registered: the block accepts in_data this cycle.
REQ-006 SHALL have port in_data, input, 24 bits: six nibbles; nibble i (bits 4i+3:4i) drives hex<i>.
REQ-007 SHALL have port blank_lz, input, 1 bit: leading-zero blanking enable, sampled at capture.
REQ-008 SHALL have ports hex0..hex5, output, 7 bits each, registered, active-low segments: bit0 = a through bit6 = g.
REQ-009 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-010 SHALL implement FSM states IDLE, DECODE, COMMIT and HOLD.
REQ-011 SHALL, in IDLE, set in_ready=1; on an edge with in_valid=1 and in_ready=1, capture in_data and blank_lz, set digit index=5, set lz_run=blank_lz, and enter DECODE.
REQ-012 SHALL ignore in_valid while in_ready=0: no capture and no queuing; in_data need not be held after the handshake.
REQ-013 SHALL, in DECODE, process one digit per cycle with the index descending 5..0, writing that digit's active-low pattern to a shadow register.
REQ-014 SHALL write 7'h7F (blank) to the shadow register when lz_run=1, the nibble is 0 and the index is not 0; any other case writes the decoded pattern and clears lz_run.
REQ-015 SHALL enter COMMIT after index 0 is written (6 DECODE cycles); COMMIT copies all six shadow registers to hex0..hex5 on the same edge, so outputs never show a partially updated value.
REQ-016 SHALL decode nibbles 0..F to the active-high patterns 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71 (hex), with the output equal to the bitwise inverse.
REQ-017 SHALL give latency from the handshake edge E0 to hex outputs changing at edge E0+7.
REQ-018 SHALL, in HOLD, count HOLD_CYCLES cycles and then enter IDLE; with HOLD_CYCLES=0, COMMIT goes directly to IDLE; in_ready returns to 1 at edge E0+7+HOLD_CYCLES.
REQ-019 SHALL use a hold counter wide enough for HOLD_CYCLES (clog2, minimum 1 bit) that saturates and never wraps.
REQ-020 SHALL keep hex0..hex5 constant in all states except at the COMMIT edge.

Reset
REQ-021 SHALL, while rst_n=0 at a clock edge, set state=IDLE, hex0..hex5=7'h40 ("0"), all shadow registers=7'h40, in_ready=1, busy=0, index=5, lz_run=0 and hold counter=0.
REQ-022 SHALL treat reset in DECODE, COMMIT or HOLD as an abort: captured data is discarded and outputs take their reset values.
REQ-023 SHALL take priority for reset over a simultaneous handshake.

Structure
REQ-024 SHALL place the FSM state encoding, the digit count (6) and the blank constant 7'h7F in a shared display package.
REQ-025 SHALL instantiate exactly one combinational sub-module, seg7_lut (4-bit in, 7-bit active-low out), time-shared across all digits.

Verification (bench HOLD_CYCLES=4)
REQ-026 SHALL verify reset: after reset, all hex=0x40, in_ready=1 and busy=0.
REQ-027 SHALL verify decode: in_data=0x0123AB, blank_lz=0 -> at E0+7, hex5..hex0 = 40,79,24,30,08,03; in_ready=1 at E0+11.
REQ-028 SHALL verify blanking: blank_lz=1 with 0x000000 -> hex5..hex1=7F, hex0=40; blank_lz=1 with 0x000F00 -> hex5..hex3=7F, hex2=0E, hex1=40, hex0=40.
REQ-029 SHALL verify back-to-back: in_valid held high with changing data -> exactly one capture per 11 cycles, hex stable between COMMIT edges, and each capture is the in_data present on its handshake edge.
REQ-030 SHALL verify abort: rst_n low at E0+3 during DECODE of 0xFFFFFF -> all hex=0x40 and in_ready=1, with 0xFFFFFF never displayed.
REQ-031 SHALL verify HOLD_CYCLES=0: consecutive handshakes are 7 cycles apart.
